// File: rtl/dmem_bridge.sv
// dmem_bridge: routes core data accesses to SRAM (low half) or an MMIO block
// with a 64-bit timer, a scratch register and a byte TX FIFO (high half).
module dmem_bridge #(
  parameter int TX_DEPTH = 4,
  parameter int CW       = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] dat_a,
  input  logic [3:0]  dat_we,
  input  logic [31:0] dat_wd,
  input  logic [3:0]  dat_re,
  output logic [31:0] dat_rd,
  output logic [15:0] ram_a,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wd,
  output logic [3:0]  ram_re,
  input  logic [31:0] ram_rd,
  output logic        tx_vld,
  output logic [7:0]  tx_dat,
  input  logic        tx_rdy
);
  logic          is_mmio, rd_acc, empty, full, push, pop, acc, ovf_clr;
  logic [2:0]    widx;
  logic [31:0]   rd_val, status;
  logic          sel_q, sel_d;
  logic [31:0]   mmio_rd_q, mmio_rd_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [31:0]   hi_shadow_q, hi_shadow_d, scratch_q, scratch_d;
  logic [7:0]    mem_q [TX_DEPTH];
  logic [7:0]    mem_d [TX_DEPTH];
  logic [CW-2:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    is_mmio = dat_a[15];
    widx    = dat_a[4:2];
    rd_acc  = is_mmio & |dat_re;
    empty   = cnt_q == '0;
    full    = cnt_q == CW'(TX_DEPTH);
    pop     = !empty & tx_rdy;
    push    = is_mmio & (widx == 3'd3) & dat_we[0];
    // a full FIFO still accepts a push when the sink frees a slot this cycle
    acc     = push & (!full | pop);
    ovf_clr = is_mmio & (widx == 3'd4) & dat_we[0] & dat_wd[3];
    status  = 32'({cnt_q, ovf_q, 1'b0, empty, full});
    rd_val  = widx == 3'd0 ? mtime_q[31:0] :
              widx == 3'd1 ? hi_shadow_q :
              widx == 3'd2 ? scratch_q :
              widx == 3'd4 ? status : 32'h0;
    sel_d       = rd_acc;
    mmio_rd_d   = rd_acc ? rd_val : 32'h0;
    mtime_d     = mtime_q + 64'd1;
    hi_shadow_d = (rd_acc & (widx == 3'd0)) ? mtime_q[63:32] : hi_shadow_q;
    scratch_d   = scratch_q;
    for (int i = 0; i < 4; i++)
      if (is_mmio & (widx == 3'd2) & dat_we[i]) scratch_d[8*i +: 8] = dat_wd[8*i +: 8];
    mem_d = mem_q;
    if (acc) mem_d[wr_ptr_q] = dat_wd[7:0];
    wr_ptr_d = wr_ptr_q + (CW-1)'(acc);
    rd_ptr_d = rd_ptr_q + (CW-1)'(pop);
    cnt_d    = cnt_q + CW'(acc) - CW'(pop);
    ovf_d    = (push & full & !pop) | (ovf_q & !ovf_clr);
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sel_q       <= 1'b0;
      mmio_rd_q   <= '0;
      mtime_q     <= '0;
      hi_shadow_q <= '0;
      scratch_q   <= '0;
      mem_q       <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      mmio_rd_q   <= mmio_rd_d;
      mtime_q     <= mtime_d;
      hi_shadow_q <= hi_shadow_d;
      scratch_q   <= scratch_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end

  assign ram_a  = dat_a;
  assign ram_wd = dat_wd;
  assign ram_we = is_mmio ? 4'h0 : dat_we;
  assign ram_re = is_mmio ? 4'h0 : dat_re;
  assign dat_rd = sel_q ? mmio_rd_q : ram_rd;
  assign tx_vld = !empty;
  assign tx_dat = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed and random accesses checked against a queue-based
// model of the MMIO registers and TX FIFO plus a behavioural SRAM.
module tb_dmem_bridge;
  localparam int D = 4;
  logic        clk = 0, rstn = 0;
  logic [15:0] dat_a = '0;
  logic [3:0]  dat_we = '0, dat_re = '0;
  logic [31:0] dat_wd = '0, dat_rd;
  logic [15:0] ram_a;
  logic [3:0]  ram_we, ram_re;
  logic [31:0] ram_wd, ram_rd = '0;
  logic        tx_vld, tx_rdy = 0;
  logic [7:0]  tx_dat;
  logic [31:0] ram [64];
  int          n_run = 0, n_fail = 0;
  logic [7:0]  q[$];
  bit          ovf_m;
  logic [31:0] scr_m, shd_m, last_rd;
  logic [63:0] mt_m;

  dmem_bridge #(.TX_DEPTH(D), .CW(3)) dut (
    .clk(clk), .rstn(rstn), .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd),
    .dat_re(dat_re), .dat_rd(dat_rd), .ram_a(ram_a), .ram_we(ram_we),
    .ram_wd(ram_wd), .ram_re(ram_re), .ram_rd(ram_rd), .tx_vld(tx_vld),
    .tx_dat(tx_dat), .tx_rdy(tx_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) ram[ram_a[7:2]][8*i +: 8] <= ram_wd[8*i +: 8];
    if (|ram_re) ram_rd <= ram[ram_a[7:2]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 0;
    scr_m = '0;
    shd_m = '0;
    mt_m  = '0;
  endtask

  task automatic cyc(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                     input logic [3:0] re, input logic rdy);
    logic [31:0] exp;
    logic [2:0]  w;
    bit          popm, fullm;
    dat_a = a; dat_we = we; dat_wd = wd; dat_re = re; tx_rdy = rdy;
    #1;
    check("ram_we", ram_we, a[15] ? 4'h0 : we);
    check("ram_re", ram_re, a[15] ? 4'h0 : re);
    check("ram_a", ram_a, a);
    w     = a[4:2];
    popm  = q.size() > 0 && rdy;
    fullm = q.size() == D;
    exp   = '0;
    if (!a[15]) exp = ram[a[7:2]];
    else if (w == 0) exp = mt_m[31:0];
    else if (w == 1) exp = shd_m;
    else if (w == 2) exp = scr_m;
    else if (w == 4) exp = 32'(q.size()) * 16 + (ovf_m ? 8 : 0) + (q.size() == 0 ? 2 : 0) + (fullm ? 1 : 0);
    if (a[15] && |re && w == 0) shd_m = mt_m[63:32];
    if (a[15] && w == 2)
      for (int i = 0; i < 4; i++) if (we[i]) scr_m[8*i +: 8] = wd[8*i +: 8];
    if (a[15] && w == 4 && we[0] && wd[3]) ovf_m = 0;
    if (popm) void'(q.pop_front());
    if (a[15] && w == 3 && we[0]) begin
      if (fullm && !popm) ovf_m = 1;
      else q.push_back(wd[7:0]);
    end
    mt_m++;
    @(posedge clk);
    #1;
    if (|re) check("dat_rd", dat_rd, exp);
    last_rd = dat_rd;
    check("tx_vld", tx_vld, q.size() > 0);
    if (q.size() > 0) check("tx_dat", tx_dat, q[0]);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_dat_rd", dat_rd, 0);
    check("rst_tx_vld", tx_vld, 0);
    check("rst_tx_dat", tx_dat, 0);
    rstn = 1;
    // scratch byte-enable write
    cyc(16'h8008, 4'h0, 0, 4'hF, 0);
    check("scratch_rst", last_rd, 32'h0);
    cyc(16'h8008, 4'h5, 32'hA5A5A5A5, 4'h0, 0);
    cyc(16'h8008, 4'h0, 0, 4'hF, 0);
    check("scratch_be", last_rd, 32'h00A500A5);
    // SRAM pass-through and back-to-back source switching
    cyc(16'h0010, 4'hF, 32'h12345678, 4'h0, 0);
    cyc(16'h0010, 4'h0, 0, 4'hF, 0);
    check("sram_rd", last_rd, 32'h12345678);
    cyc(16'h8010, 4'h0, 0, 4'hF, 0);
    check("b2b_mmio", last_rd, 32'h2);
    cyc(16'h0010, 4'h0, 0, 4'hF, 0);
    check("b2b_sram", last_rd, 32'h12345678);
    // overflow with sink stalled, then drain
    for (int i = 0; i < 5; i++) cyc(16'h800C, 4'h1, 32'h41 + i, 4'h0, 0);
    cyc(16'h8010, 4'h0, 0, 4'hF, 0);
    check("status_full_ovf", last_rd, 32'h49);
    for (int i = 0; i < 4; i++) cyc(16'h0000, 4'h0, 0, 4'h0, 1);
    cyc(16'h8010, 4'h0, 0, 4'hF, 0);
    check("status_drained", last_rd, 32'h0A);
    // full FIFO push with simultaneous pop
    cyc(16'h8010, 4'h1, 32'h8, 4'h0, 0);
    for (int i = 0; i < 4; i++) cyc(16'h800C, 4'h1, 32'h41 + i, 4'h0, 0);
    cyc(16'h800C, 4'h1, 32'h55, 4'h0, 1);
    cyc(16'h8010, 4'h0, 0, 4'hF, 0);
    check("status_push_pop", last_rd, 32'h41);
    for (int i = 0; i < 5; i++) cyc(16'h0000, 4'h0, 0, 4'h0, 1);
    // tear-free timer read across the low-word wrap
    dut.mtime_q = 64'h0000_0000_FFFF_FFFF;
    mt_m = 64'h0000_0000_FFFF_FFFF;
    cyc(16'h8000, 4'h0, 0, 4'hF, 0);
    check("mtime_lo", last_rd, 32'hFFFFFFFF);
    cyc(16'hFFE4, 4'h0, 0, 4'hF, 0);
    check("mtime_hi", last_rd, 32'h0);
    // reset mid-stream
    cyc(16'h800C, 4'h1, 32'h77, 4'h0, 0);
    cyc(16'h800C, 4'h1, 32'h78, 4'h0, 0);
    rstn = 0;
    #1;
    check("midrst_tx_vld", tx_vld, 0);
    check("midrst_tx_dat", tx_dat, 0);
    rstn = 1;
    model_reset();
    cyc(16'h8010, 4'h0, 0, 4'hF, 0);
    check("midrst_status", last_rd, 32'h2);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [15:0] a;
      logic [3:0]  we, re;
      r  = $urandom_range(0, 3);
      a  = r == 0 ? 16'($urandom) & 16'h7FFF
                  : {1'b1, 10'($urandom), r == 1 ? 3'd3 : 3'($urandom_range(0, 7)), 2'($urandom)};
      we = r == 1 ? 4'h1 : ($urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0);
      re = $urandom_range(0, 1) == 0 ? 4'($urandom) : 4'h0;
      cyc(a, we, $urandom, re, $urandom_range(0, 2) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the core's data port (dat_*), between the core and the data SRAM (sram1).
- Decodes each access by address. Low half goes to the SRAM. High half goes to an internal MMIO block.
- MMIO block holds a 64-bit cycle timer, a scratch register and a byte TX FIFO. The FIFO drains through a valid/ready stream.
- Read latency to the core is one cycle for both targets, matching the SRAM.

Parameters:
TX_DEPTH, 4, TX FIFO entries; power of two, 2..16.
CW, 3, count width = log2(TX_DEPTH)+1.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
dat_a  in  16  core byte address
dat_we  in  4  core byte write enables
dat_wd  in  32  core write data
dat_re  in  4  core byte read enables
dat_rd  out  32  read data to core, valid the cycle after dat_re
ram_a  out  16  SRAM address (dat_a passed through)
ram_we  out  4  SRAM write enables
ram_wd  out  32  SRAM write data (dat_wd passed through)
ram_re  out  4  SRAM read enables
ram_rd  in  32  SRAM read data, one cycle after ram_re
tx_vld  out  1  TX byte valid
tx_dat  out  8  TX byte
tx_rdy  in  1  TX sink ready

Behaviour:
- Reset is asynchronous, active-low. All sequential state clears: sel_q=0, mmio_rd_q=0, mtime=0, hi_shadow=0, scratch=0, FIFO empty (rd/wr ptr=0, count=0), ovf=0.
- Reset output values: dat_rd=0, tx_vld=0, tx_dat=0.
- Decode: is_mmio = dat_a[15].
  - ram_we = is_mmio ? 0 : dat_we; ram_re = is_mmio ? 0 : dat_re (combinational).
- Read path:
  - sel_q <= is_mmio & |dat_re.
  - mmio_rd_q <= register read value when is_mmio & |dat_re, else 0.
  - dat_rd = sel_q ? mmio_rd_q : ram_rd.
  - Byte lane extraction and sign extension are done by the core's LSU; the bridge returns the full word.
- MMIO map, word index dat_a[4:2], dat_a[14:5] ignored (aliases):
  - 0 MTIME_LO (RO): returns mtime[31:0] and captures mtime[63:32] into hi_shadow in the same cycle.
  - 1 MTIME_HI (RO): returns hi_shadow. A LO-then-HI read pair is therefore tear-free.
  - 2 SCRATCH (RW): byte-enable write per dat_we[i].
  - 3 TX_DATA (WO): write with dat_we[0]=1 pushes dat_wd[7:0]. Reads return 0.
  - 4 TX_STATUS: read {.., count[CW-1:0] at [CW+3:4], ovf[3], 0[2], empty[1], full[0]}, upper bits 0. Write with dat_we[0]=1 and dat_wd[3]=1 clears ovf.
  - 5..7: read 0, writes ignored.
- Writes to RO registers are ignored. Simultaneous dat_we and dat_re on one access: the write takes effect and the read returns the pre-write value.
- mtime increments by 1 every cycle and wraps 2^64-1 -> 0.
- TX FIFO:
  - pop = tx_vld & tx_rdy. push = MMIO write to TX_DATA with dat_we[0].
  - tx_vld = !empty; tx_dat = mem[rd_ptr] (first-word-fall-through).
  - Push when not full: stored at wr_ptr. Pointers wrap modulo TX_DEPTH.
  - Push when full and no pop: byte dropped, ovf <= 1 (sticky).
  - Push when full with a pop in the same cycle: accepted, count unchanged, no ovf.
  - Push when empty: tx_vld rises the next cycle. There is no same-cycle bypass.
  - Push and pop in the same cycle otherwise: count unchanged.
  - ovf clear and a new overflow in the same cycle: ovf stays 1.
- Reset mid-operation: FIFO contents are discarded. Any read returning the next cycle yields dat_rd=0 while the MMIO path is selected; the SRAM path is not gated.

Test Plan:
- After reset, read 0x8008 -> dat_rd=0x00000000 next cycle. Write 0x8008 wd=0xA5A5A5A5 we=4'b0101 -> read 0x00A500A5. ram_we/ram_re stay 0 throughout.
- Write SRAM 0x0010=0x12345678, then read it -> ram_we=4'hF passed through; dat_rd=0x12345678 one cycle after re. Back-to-back read 0x8010 then 0x0010 returns the correct source each cycle.
- Hold tx_rdy=0 and push 0x41,0x42,0x43,0x44,0x45 -> status reads full=1, count=4, ovf=1. Raise tx_rdy -> tx_dat streams 0x41..0x44 on consecutive cycles, then tx_vld=0 and empty=1.
- FIFO full, tx_rdy=1 and push 0x55 in the same cycle -> count stays 4, ovf stays 0. 0x55 emerges fifth.
- Force mtime to 0x00000000_FFFFFFFF, then read LO then HI -> LO=0xFFFFFFFF, HI=0x00000000 (shadow), even though mtime has wrapped into the upper word.
- Assert rstn low mid-stream with 2 bytes queued -> tx_vld=0 immediately. After release, status=0x00000002 (empty only).
